cell_bus_arbiter: RTL

- Shares one occupancy_grid cell-access port among NUM_REQ requesters, e.g. collision-check lanes and the map loader.
- Grants requesters round-robin and issues exactly one cell read or write downstream at a time.
- Routes read results back to the owning requester.
- Sits between requester logic and occupancy_grid, in the memory clock domain.

---
 rtl/cell_bus_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cell_bus_arbiter.sv
// rtl/cell_bus_arbiter.sv - round-robin arbiter sharing one occupancy_grid cell-access port
// Optional feature macro: CELL_ARB_FIXED_PRIO_EN (requester 0 gets strict priority over the round-robin group)
module cell_bus_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int GRID_WIDTH_LOG2  = 8,
    parameter int GRID_HEIGHT_LOG2 = 8,
    localparam int IDX_W           = $clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_vld,
    input  logic [NUM_REQ-1:0]                    req_we,
    input  logic [NUM_REQ-1:0]                    req_w_occupied,
    input  logic [NUM_REQ*GRID_WIDTH_LOG2-1:0]    req_cell_x,
    input  logic [NUM_REQ*GRID_HEIGHT_LOG2-1:0]   req_cell_y,
    output logic [NUM_REQ-1:0]                    req_rdy,
    output logic [NUM_REQ-1:0]                    rsp_vld,
    output logic                                  rsp_occupied,
    output logic [IDX_W-1:0]                      owner_idx,
    output logic                                  busy,
    output logic                                  g_vld_in,
    output logic                                  g_we,
    output logic                                  g_w_occupied,
    output logic [GRID_WIDTH_LOG2-1:0]            g_cell_x,
    output logic [GRID_HEIGHT_LOG2-1:0]           g_cell_y,
    input  logic                                  g_rdy,
    input  logic                                  g_vld_out,
    input  logic                                  g_r_occupied
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_WAIT_WR = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last;

    // Per-requester coordinates unpacked so the winner can be selected by index.
    logic [GRID_WIDTH_LOG2-1:0]  cell_x_arr [NUM_REQ];
    logic [GRID_HEIGHT_LOG2-1:0] cell_y_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign cell_x_arr[gi] = req_cell_x[gi*GRID_WIDTH_LOG2 +: GRID_WIDTH_LOG2];
            assign cell_y_arr[gi] = req_cell_y[gi*GRID_HEIGHT_LOG2 +: GRID_HEIGHT_LOG2];
        end
    endgenerate

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_upd_last;
    logic [IDX_W-1:0] cand;
    int               sum;

    // Winner search: first pending requester after the last round-robin grant, wrapping.
    always_comb begin
        pick_vld      = 1'b0;
        pick_idx      = '0;
        pick_upd_last = 1'b1;
        cand          = '0;
        sum           = 0;
`ifdef CELL_ARB_FIXED_PRIO_EN
        if (req_vld[0]) begin
            // Requester 0 bypasses the rotation and leaves the pointer untouched.
            pick_vld      = 1'b1;
            pick_idx      = '0;
            pick_upd_last = 1'b0;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                sum = int'(last) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                cand = IDX_W'(sum);
                if (!pick_vld && (cand != '0) && req_vld[cand]) begin
                    pick_vld = 1'b1;
                    pick_idx = cand;
                end
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = int'(last) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = IDX_W'(sum);
            if (!pick_vld && req_vld[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
`endif
    end

    // Transaction FSM: grant, issue one downstream access, wait for its completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last         <= IDX_W'(NUM_REQ - 1);
            req_rdy      <= '0;
            rsp_vld      <= '0;
            rsp_occupied <= 1'b0;
            owner_idx    <= '0;
            busy         <= 1'b0;
            g_vld_in     <= 1'b0;
            g_we         <= 1'b0;
            g_w_occupied <= 1'b0;
            g_cell_x     <= '0;
            g_cell_y     <= '0;
        end else begin
            // Grant, request and response strobes are single-cycle pulses.
            req_rdy  <= '0;
            rsp_vld  <= '0;
            g_vld_in <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (g_rdy && pick_vld) begin
                        g_vld_in          <= 1'b1;
                        g_we              <= req_we[pick_idx];
                        g_w_occupied      <= req_w_occupied[pick_idx];
                        g_cell_x          <= cell_x_arr[pick_idx];
                        g_cell_y          <= cell_y_arr[pick_idx];
                        req_rdy[pick_idx] <= 1'b1;
                        owner_idx         <= pick_idx;
                        if (pick_upd_last) begin
                            last <= pick_idx;
                        end
                        busy  <= 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // g_* fields stay put until the next grant.
                    state <= g_we ? ST_WAIT_WR : ST_WAIT_RD;
                end
                ST_WAIT_RD: begin
                    if (g_vld_out) begin
                        rsp_vld[owner_idx] <= 1'b1;
                        rsp_occupied       <= g_r_occupied;
                        busy               <= 1'b0;
                        state              <= ST_IDLE;
                    end
                end
                ST_WAIT_WR: begin
                    if (g_rdy) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
